acia_host: RTL and testbench

ACIA_HOST -- requirements
Module: acia_host

---
 rtl/acia_host.sv | 188 ++++++++++++++++++
 tb/tb_acia_host.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_host.sv
`default_nettype none
// ============================================================================
// Module   : acia_host
// Brief    : Polling host for a 6850-style ACIA. It runs the init writes,
//            polls status, and moves bytes between the ACIA and TX/RX streams.
//            ACIA_HOST_RXFIFO_EN selects a 4-entry RX FIFO; when it is not
//            defined, RX uses a single holding register.
// Revision : 1.0 - initial release
// ============================================================================
module acia_host #(
    parameter logic [7:0] CTRL_WORD = 8'h15
) (
    input  logic       clk,
    input  logic       rst,
    output logic       cs,
    output logic       we,
    output logic       rs,
    output logic [7:0] dout,
    input  logic [7:0] din,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err
);

    typedef enum logic [2:0] {
        INIT_RST = 3'd0,
        INIT_CFG = 3'd1,
        POLL_REQ = 3'd2,
        POLL_CAP = 3'd3,
        RD_REQ   = 3'd4,
        RD_CAP   = 3'd5,
        WR       = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] status_q;
    logic       cap_q;
    logic       rx_full;
    logic       rx_push;
    logic       rx_pop;
    logic       unused_status;

    assign rx_push = (state_q == RD_CAP);
    assign rx_pop  = rx_valid & rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus strobes depend on state_q only. din affects only the next state.
    always_comb begin
        state_d  = state_q;
        cs       = 1'b0;
        we       = 1'b0;
        rs       = 1'b0;
        dout     = 8'h00;
        tx_ready = 1'b0;
        case (state_q)
            INIT_RST: begin
                cs      = 1'b1;
                we      = 1'b1;
                dout    = 8'h03;
                state_d = INIT_CFG;
            end
            INIT_CFG: begin
                cs      = 1'b1;
                we      = 1'b1;
                dout    = CTRL_WORD;
                state_d = POLL_REQ;
            end
            POLL_REQ: begin
                cs      = 1'b1;
                state_d = POLL_CAP;
            end
            POLL_CAP: begin
                if (din[0] && !rx_full) begin
                    state_d = RD_REQ;
                end else if (din[1] && tx_valid) begin
                    state_d = WR;
                end else begin
                    state_d = POLL_REQ;
                end
            end
            RD_REQ: begin
                cs      = 1'b1;
                rs      = 1'b1;
                state_d = RD_CAP;
            end
            RD_CAP: begin
                state_d = POLL_REQ;
            end
            WR: begin
                cs       = 1'b1;
                we       = 1'b1;
                rs       = 1'b1;
                dout     = tx_data;
                tx_ready = 1'b1;
                state_d  = POLL_REQ;
            end
            default: begin
                state_d = INIT_RST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= 8'h00;
            cap_q    <= 1'b0;
        end else begin
            cap_q <= (state_q == POLL_CAP);
            if (state_q == POLL_CAP) begin
                status_q <= din;
            end
        end
    end

    // cap_q is high only in the cycle after a capture, so rx_err is a single-cycle pulse.
    assign rx_err        = cap_q & status_q[4];
    assign unused_status = ^{status_q[7:5], status_q[3:0]};

`ifdef ACIA_HOST_RXFIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (rx_push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (rx_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({rx_push, rx_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign rx_full  = (count_q == 3'd4);
    assign rx_valid = (count_q != 3'd0);
    assign rx_data  = mem_q[rd_ptr_q];
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;

    // A push never meets a full register: POLL_CAP reads only when the register is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
        end else if (rx_push) begin
            hold_q     <= din;
            hold_vld_q <= 1'b1;
        end else if (rx_pop) begin
            hold_vld_q <= 1'b0;
        end
    end

    assign rx_full  = hold_vld_q;
    assign rx_valid = hold_vld_q;
    assign rx_data  = hold_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_acia_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_acia_host
// Brief    : Bench for acia_host. It uses a behavioural ACIA and a
//            transaction-level model of the expected bus sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acia_host;

`ifdef ACIA_HOST_RXFIFO_EN
    localparam int CAP      = 4;
    localparam int PEND_EXP = 1;
`else
    localparam int CAP      = 1;
    localparam int PEND_EXP = 4;
`endif
    localparam logic [7:0] CTRL = 8'h15;

    localparam logic [2:0] K_WRC  = 3'd0;
    localparam logic [2:0] K_POLL = 3'd1;
    localparam logic [2:0] K_CAP  = 3'd2;
    localparam logic [2:0] K_RD   = 3'd3;
    localparam logic [2:0] K_RCAP = 3'd4;
    localparam logic [2:0] K_WR   = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] val;
    } bus_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       cs, we, rs;
    logic [7:0] dout;
    logic [7:0] din      = 8'h00;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] src_bytes[$];
    int         rd_idx     = 0;
    int         err_req    = 0;
    int         err_served = 0;
    logic       tdre       = 1'b0;
    logic [7:0] tx_log[$];
    logic [9:0] bus_log[$];
    int         txr_cnt    = 0;
    int         err_cnt    = 0;

    acia_host dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .rs       (rs),
        .dout     (dout),
        .din      (din),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_err   (rx_err)
    );

    always #5 clk = ~clk;

    // ACIA: read data is registered; a status read clears one pending error.
    always @(posedge clk) begin : acia_model
        logic [7:0] st;
        if (!rst) begin
            if (cs) bus_log.push_back({we, rs, dout});
            if (tx_ready) txr_cnt++;
            if (rx_err) err_cnt++;
            if (cs && !we) begin
                if (rs) begin
                    if (rd_idx < src_bytes.size()) begin
                        din <= src_bytes[rd_idx];
                        rd_idx++;
                    end else begin
                        din <= 8'h00;
                    end
                end else begin
                    st = {3'b000, (err_served < err_req), 2'b00, tdre, (rd_idx < src_bytes.size())};
                    if (st[4]) err_served++;
                    din <= st;
                end
            end else if (cs && we && rs) begin
                tx_log.push_back(dout);
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bus_t mk(input logic [2:0] k, input logic [7:0] v);
        bus_t r;
        r.kind = k;
        r.val  = v;
        return r;
    endfunction

    // Expected bus cycles are queued as transactions. Each poll-capture
    // decides the next transaction from status, buffer room and TX offer.
    task automatic model_loop();
        bus_t       exp_q[$];
        logic [7:0] mq[$];
        logic       err_pend;
        logic       exp_cs;
        bus_t       e;
        err_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk1("rst_cs", cs, 1'b1);
                chk1("rst_we", we, 1'b1);
                chk1("rst_rs", rs, 1'b0);
                chk8("rst_dout", dout, 8'h03);
                chk1("rst_tx_ready", tx_ready, 1'b0);
                chk1("rst_rx_valid", rx_valid, 1'b0);
                chk1("rst_rx_err", rx_err, 1'b0);
                exp_q.delete();
                exp_q.push_back(mk(K_WRC, 8'h03));
                exp_q.push_back(mk(K_WRC, CTRL));
                exp_q.push_back(mk(K_POLL, 8'h00));
                mq.delete();
                err_pend = 1'b0;
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL model_sequence: got no expected transaction, required one at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                exp_cs = !(e.kind == K_CAP || e.kind == K_RCAP);
                chk1("bus_cs", cs, exp_cs);
                if (exp_cs) begin
                    chk1("bus_we", we, (e.kind == K_WRC) || (e.kind == K_WR));
                    chk1("bus_rs", rs, (e.kind == K_RD) || (e.kind == K_WR));
                end
                chk8("bus_dout", dout, ((e.kind == K_WRC) || (e.kind == K_WR)) ? e.val : 8'h00);
                chk1("tx_ready", tx_ready, e.kind == K_WR);
                chk1("rx_err", rx_err, err_pend);
                err_pend = 1'b0;
                chk1("rx_valid", rx_valid, mq.size() != 0);
                if (mq.size() != 0) chk8("rx_data", rx_data, mq[0]);
                if (e.kind == K_POLL) begin
                    exp_q.push_back(mk(K_CAP, 8'h00));
                end else if (e.kind == K_CAP) begin
                    err_pend = din[4];
                    if (din[0] && mq.size() < CAP) begin
                        exp_q.push_back(mk(K_RD, 8'h00));
                        exp_q.push_back(mk(K_RCAP, 8'h00));
                    end else if (din[1] && tx_valid) begin
                        exp_q.push_back(mk(K_WR, tx_data));
                    end
                    exp_q.push_back(mk(K_POLL, 8'h00));
                end
                if (mq.size() != 0 && rx_ready) void'(mq.pop_front());
                if (e.kind == K_RCAP) mq.push_back(din);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_tx(input logic [7:0] b);
        logic seen;
        seen     = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tx_ready) seen = 1'b1;
        end
        chk1("tx_accepted", seen, 1'b1);
        @(posedge clk);
        #2;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic check_init(input int m);
        chk1("init_log_len", bus_log.size() >= m + 3, 1'b1);
        if (bus_log.size() >= m + 3) begin
            chk10("init_master_reset", bus_log[m], {1'b1, 1'b0, 8'h03});
            chk10("init_ctrl_word", bus_log[m+1], {1'b1, 1'b0, 8'h15});
            chk10("init_first_poll", bus_log[m+2], {1'b0, 1'b0, 8'h00});
        end
    endtask

    task automatic run_tests();
        int         mark, t0, tl0, e0, p, q;
        logic [7:0] got[$];
        logic       found;

        tick(3);
        chk1("reset_cs", cs, 1'b1);
        chk1("reset_we", we, 1'b1);
        chk1("reset_rs", rs, 1'b0);
        chk8("reset_dout", dout, 8'h03);
        chk1("reset_tx_ready", tx_ready, 1'b0);
        chk1("reset_rx_valid", rx_valid, 1'b0);
        chk1("reset_rx_err", rx_err, 1'b0);
        mark = bus_log.size();
        rst  = 1'b0;
        tick(4);
        check_init(mark);

        // TX only: status 02 with byte 41 offered
        tdre = 1'b1;
        t0   = txr_cnt;
        tl0  = tx_log.size();
        send_tx(8'h41);
        tick(8);
        chkn("tx_ready_pulses", txr_cnt - t0, 1);
        chkn("tx_write_count", tx_log.size() - tl0, 1);
        if (tx_log.size() > tl0) chk8("tx_byte", tx_log[tl0], 8'h41);

        // Status 03: RX read comes before the TX write
        tdre = 1'b0;
        tick(6);
        mark = bus_log.size();
        src_bytes.push_back(8'h5A);
        tdre = 1'b1;
        send_tx(8'h42);
        tick(4);
        p = -1;
        q = -1;
        for (int i = mark; i < bus_log.size(); i++) begin
            if (bus_log[i][8]) begin
                if (p < 0) p = i;
                else if (q < 0) q = i;
            end
        end
        chk1("data_accesses_found", (p >= 0) && (q >= 0), 1'b1);
        if (p >= 0) chk10("first_data_access_read", bus_log[p], {1'b0, 1'b1, 8'h00});
        if (q >= 0) chk10("second_data_access_write", bus_log[q], {1'b1, 1'b1, 8'h42});
        chk1("rx_valid_5a", rx_valid, 1'b1);
        chk8("rx_data_5a", rx_data, 8'h5A);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        chk1("rx_popped", rx_valid, 1'b0);

        // Status 10: single error pulse
        tdre = 1'b0;
        e0   = err_cnt;
        err_req++;
        tick(12);
        chkn("rx_err_pulses", err_cnt - e0, 1);

        // Back-pressure: five bytes offered with the consumer stalled
        for (int i = 1; i <= 5; i++) src_bytes.push_back(8'(i));
        tick(60);
        chk1("full_rx_valid", rx_valid, 1'b1);
        chk8("full_rx_head", rx_data, 8'h01);
        chkn("acia_pending", src_bytes.size() - rd_idx, PEND_EXP);
        rx_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 300 && got.size() < 5; i++) begin
            @(negedge clk);
            if (rx_valid) got.push_back(rx_data);
        end
        @(posedge clk);
        #2;
        rx_ready = 1'b0;
        chkn("drain_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) chk8("drain_order", got[i], 8'(i + 1));

        // Reset while RD_REQ is active
        src_bytes.push_back(8'h77);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (cs && !we && rs) found = 1'b1;
        end
        chk1("rd_req_seen", found, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("abort_cs", cs, 1'b1);
        chk1("abort_we", we, 1'b1);
        chk1("abort_rs", rs, 1'b0);
        chk8("abort_dout", dout, 8'h03);
        chk1("abort_tx_ready", tx_ready, 1'b0);
        chk1("abort_rx_valid", rx_valid, 1'b0);
        chk1("abort_rx_err", rx_err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        mark = bus_log.size();
        rst  = 1'b0;
        tick(4);
        check_init(mark);
        tick(20);
        chk1("post_reset_rx_valid", rx_valid, 1'b1);
        chk8("post_reset_rx_data", rx_data, 8'h77);
        rx_ready = 1'b1;
        tick(2);
        rx_ready = 1'b0;
        tick(2);
    endtask

    initial begin
        fork
            model_loop();
            run_tests();
            begin
                #400000;
                checks++;
                failures++;
                $display("FAIL global_timeout: got no completion, required completion before 400000");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
